// File: rtl/driver_pkg.sv
// Shared driver types and helpers: histogram bin math, saturating increment
// and the default FIFO thresholds.
package driver_pkg;

    localparam int ADDR_THRESHOLD_DEFAULT   = 820;
    localparam int VECTOR_THRESHOLD_DEFAULT = 7500;

    function automatic int calc_nbins(input int max_cnt, input int cnt_range);
        return max_cnt / cnt_range;
    endfunction

    // Values past the covered range all land in the last bin.
    function automatic int bin_index(input logic [31:0] value, input int cnt_range,
                                     input int nbins);
        int idx;
        idx = int'(value / 32'(cnt_range));
        return (idx >= nbins) ? nbins - 1 : idx;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/addr_fifo_ram.sv
// Simple dual-port DEPTH x 32 RAM with a registered read port, written so
// synthesis maps it onto block RAM.
module addr_fifo_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array and read register get no reset; a reset term would stop
    // block-RAM inference, and the FIFO pointers already mark the contents invalid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/addr_fifo_mon.sv
// Address FIFO with occupancy/sticky flags and inter-pop histograms.
// Histograms are built only when ADDR_FIFO_MON_HIST_EN is defined.
module addr_fifo_mon
    import driver_pkg::*;
#(
    parameter int DEPTH              = 1024,
    parameter int ADDR_MON_CNT_RANGE = 8,
    parameter int ADDR_MON_CNT_SIZE  = 16,
    parameter int MAX_ADDR_CYCLE_CNT = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr_fifo_wr,
    input  logic [31:0] addr_fifo_din,
    input  logic        addr_rd_en,
    output logic [31:0] addr_dout,
    output logic        addr_dout_vld,
    input  logic        active_program,
    input  logic        freeze_addr_fifo,
    input  logic [15:0] addr_fifo_threshold,
    output logic [15:0] words_in_addr_fifo,
    output logic        addr_fifo_full,
    output logic        addr_fifo_empty,
    output logic        addr_fifo_almost_full,
    output logic        addr_fifo_overrun,
    output logic        addr_fifo_underrun,
    output logic [15:0] addr_cycle_cnt,
    output logic [calc_nbins(MAX_ADDR_CYCLE_CNT, ADDR_MON_CNT_RANGE)*ADDR_MON_CNT_SIZE-1:0] addr_mon_cnts,
    output logic [calc_nbins(MAX_ADDR_CYCLE_CNT, ADDR_MON_CNT_RANGE)*ADDR_MON_CNT_SIZE-1:0] addr_fifo_mon_cnts
);

    localparam int AW    = $clog2(DEPTH);
    localparam int NBINS = calc_nbins(MAX_ADDR_CYCLE_CNT, ADDR_MON_CNT_RANGE);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr, rd_ptr, count, count_nxt;
    logic        do_wr, do_pop, pop_d, active_d, prog_start;
    logic [31:0] ram_rd_data;

    assign count           = wr_ptr - rd_ptr;
    assign addr_fifo_empty = (wr_ptr == rd_ptr);
    assign addr_fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign words_in_addr_fifo = 16'(count);

    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    assign do_pop     = addr_rd_en && !addr_fifo_empty && !freeze_addr_fifo;
    assign do_wr      = addr_fifo_wr && (!addr_fifo_full || do_pop);
    assign count_nxt  = count + (do_wr ? PTR_ONE : '0) - (do_pop ? PTR_ONE : '0);
    assign prog_start = active_program && !active_d;

    addr_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (addr_fifo_din),
        .rd_en   (do_pop),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            pop_d                 <= 1'b0;
            addr_dout             <= '0;
            addr_dout_vld         <= 1'b0;
            addr_fifo_almost_full <= 1'b0;
            active_d              <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            pop_d         <= do_pop;
            addr_dout_vld <= pop_d;
            if (pop_d) addr_dout <= ram_rd_data;
            addr_fifo_almost_full <= (16'(count_nxt) >= addr_fifo_threshold);
            active_d      <= active_program;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_fifo_overrun  <= 1'b0;
            addr_fifo_underrun <= 1'b0;
            addr_cycle_cnt     <= '0;
        end else if (prog_start) begin
            addr_fifo_overrun  <= 1'b0;
            addr_fifo_underrun <= 1'b0;
            addr_cycle_cnt     <= '0;
        end else begin
            if (addr_fifo_wr && addr_fifo_full && !do_pop) addr_fifo_overrun <= 1'b1;
            if (addr_rd_en && addr_fifo_empty && !freeze_addr_fifo) addr_fifo_underrun <= 1'b1;
            if (active_program)
                addr_cycle_cnt <= do_pop ? '0 : 16'(sat_inc(32'(addr_cycle_cnt), 16));
        end
    end

`ifdef ADDR_FIFO_MON_HIST_EN
    logic [ADDR_MON_CNT_SIZE-1:0] mon_bins  [NBINS];
    logic [ADDR_MON_CNT_SIZE-1:0] fifo_bins [NBINS];
    logic [15:0] empty_run;
    logic        run_done;
    int          pop_bin, run_bin;

    assign pop_bin  = bin_index(32'(addr_cycle_cnt), ADDR_MON_CNT_RANGE, NBINS);
    assign run_bin  = bin_index(32'(empty_run), ADDR_MON_CNT_RANGE, NBINS);
    assign run_done = !addr_fifo_empty && (empty_run != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_run <= '0;
            for (int i = 0; i < NBINS; i++) begin
                mon_bins[i]  <= '0;
                fifo_bins[i] <= '0;
            end
        end else if (prog_start) begin
            empty_run <= '0;
            for (int i = 0; i < NBINS; i++) begin
                mon_bins[i]  <= '0;
                fifo_bins[i] <= '0;
            end
        end else if (active_program) begin
            empty_run <= addr_fifo_empty ? 16'(sat_inc(32'(empty_run), 16)) : '0;
            for (int i = 0; i < NBINS; i++) begin
                if (do_pop && pop_bin == i)
                    mon_bins[i] <= ADDR_MON_CNT_SIZE'(sat_inc(32'(mon_bins[i]), ADDR_MON_CNT_SIZE));
                if (run_done && run_bin == i)
                    fifo_bins[i] <= ADDR_MON_CNT_SIZE'(sat_inc(32'(fifo_bins[i]), ADDR_MON_CNT_SIZE));
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        addr_mon_cnts      = '0;
        addr_fifo_mon_cnts = '0;
        for (int i = 0; i < NBINS; i++) begin
            addr_mon_cnts[i*ADDR_MON_CNT_SIZE +: ADDR_MON_CNT_SIZE]      = mon_bins[i];
            addr_fifo_mon_cnts[i*ADDR_MON_CNT_SIZE +: ADDR_MON_CNT_SIZE] = fifo_bins[i];
        end
    end
`else
    assign addr_mon_cnts      = '0;
    assign addr_fifo_mon_cnts = '0;
`endif

endmodule

// File: tb/tb_addr_fifo_mon.sv
// Directed self-checking bench for addr_fifo_mon (DEPTH=1024, 16 bins of 8 cycles).
module tb_addr_fifo_mon;

    localparam int NBINS = 16;
    localparam int CSZ   = 16;
`ifdef ADDR_FIFO_MON_HIST_EN
    localparam logic [31:0] HIT = 32'd1;
`else
    localparam logic [31:0] HIT = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        addr_fifo_wr, addr_rd_en, active_program, freeze_addr_fifo;
    logic [31:0] addr_fifo_din, addr_dout;
    logic        addr_dout_vld;
    logic [15:0] addr_fifo_threshold, words_in_addr_fifo, addr_cycle_cnt;
    logic        addr_fifo_full, addr_fifo_empty, addr_fifo_almost_full;
    logic        addr_fifo_overrun, addr_fifo_underrun;
    logic [NBINS*CSZ-1:0] addr_mon_cnts, addr_fifo_mon_cnts;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_extra = 0;
    logic [31:0] exp_q [$];

    addr_fifo_mon dut (
        .clk                   (clk),
        .reset                 (reset),
        .addr_fifo_wr          (addr_fifo_wr),
        .addr_fifo_din         (addr_fifo_din),
        .addr_rd_en            (addr_rd_en),
        .addr_dout             (addr_dout),
        .addr_dout_vld         (addr_dout_vld),
        .active_program        (active_program),
        .freeze_addr_fifo      (freeze_addr_fifo),
        .addr_fifo_threshold   (addr_fifo_threshold),
        .words_in_addr_fifo    (words_in_addr_fifo),
        .addr_fifo_full        (addr_fifo_full),
        .addr_fifo_empty       (addr_fifo_empty),
        .addr_fifo_almost_full (addr_fifo_almost_full),
        .addr_fifo_overrun     (addr_fifo_overrun),
        .addr_fifo_underrun    (addr_fifo_underrun),
        .addr_cycle_cnt        (addr_cycle_cnt),
        .addr_mon_cnts         (addr_mon_cnts),
        .addr_fifo_mon_cnts    (addr_fifo_mon_cnts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] data);
        addr_fifo_wr  = 1'b1;
        addr_fifo_din = data;
        step();
        addr_fifo_wr  = 1'b0;
    endtask

    function automatic logic [31:0] mon_bin(input int i);
        return 32'(addr_mon_cnts[i*CSZ +: CSZ]);
    endfunction

    function automatic logic [31:0] fifo_bin(input int i);
        return 32'(addr_fifo_mon_cnts[i*CSZ +: CSZ]);
    endfunction

    initial begin
        reset = 1'b0;
        addr_fifo_wr = 1'b0; addr_fifo_din = '0; addr_rd_en = 1'b0;
        active_program = 1'b0; freeze_addr_fifo = 1'b0; addr_fifo_threshold = 16'd4;
        step(); step();
        check("rst_empty", 32'(addr_fifo_empty), 32'd1);
        check("rst_words", 32'(words_in_addr_fifo), 32'd0);
        check("rst_full", 32'(addr_fifo_full), 32'd0);
        check("rst_vld", 32'(addr_dout_vld), 32'd0);
        check("rst_dout", addr_dout, 32'd0);
        check("rst_af", 32'(addr_fifo_almost_full), 32'd0);
        check("rst_flags", {30'd0, addr_fifo_overrun, addr_fifo_underrun}, 32'd0);
        check("rst_cyc", 32'(addr_cycle_cnt), 32'd0);
        reset = 1'b1;
        step();

        // Three writes then three back-to-back pops
        wr(32'hA); wr(32'hB); wr(32'hC);
        check("wr3_words", 32'(words_in_addr_fifo), 32'd3);
        check("wr3_af", 32'(addr_fifo_almost_full), 32'd0);
        addr_rd_en = 1'b1;
        step();
        check("pop1_vld", 32'(addr_dout_vld), 32'd0);
        check("pop1_words", 32'(words_in_addr_fifo), 32'd2);
        step();
        check("pop2_vld", 32'(addr_dout_vld), 32'd1);
        check("pop2_dout", addr_dout, 32'hA);
        check("pop2_words", 32'(words_in_addr_fifo), 32'd1);
        step();
        check("pop3_dout", addr_dout, 32'hB);
        check("pop3_empty", 32'(addr_fifo_empty), 32'd1);
        check("pop3_words", 32'(words_in_addr_fifo), 32'd0);
        addr_rd_en = 1'b0;
        step();
        check("pop4_vld", 32'(addr_dout_vld), 32'd1);
        check("pop4_dout", addr_dout, 32'hC);
        step();
        check("pop5_vld", 32'(addr_dout_vld), 32'd0);
        check("pop_no_underrun", 32'(addr_fifo_underrun), 32'd0);

        // Almost-full at threshold 4
        wr(32'h1); wr(32'h2); wr(32'h3);
        check("af_at3", 32'(addr_fifo_almost_full), 32'd0);
        wr(32'h4);
        check("af_at4", 32'(addr_fifo_almost_full), 32'd1);
        addr_rd_en = 1'b1;
        repeat (4) step();
        addr_rd_en = 1'b0;
        step(); step();
        check("drain4_empty", 32'(addr_fifo_empty), 32'd1);
        check("drain4_af", 32'(addr_fifo_almost_full), 32'd0);

        // Pop while empty: frozen first, then unfrozen
        freeze_addr_fifo = 1'b1;
        addr_rd_en = 1'b1;
        step(); step();
        check("frz_underrun", 32'(addr_fifo_underrun), 32'd0);
        check("frz_vld", 32'(addr_dout_vld), 32'd0);
        freeze_addr_fifo = 1'b0;
        step();
        check("underrun_set", 32'(addr_fifo_underrun), 32'd1);
        addr_rd_en = 1'b0;
        step();
        check("underrun_no_vld", 32'(addr_dout_vld), 32'd0);

        // Fill past full
        for (int i = 0; i < 1025; i++) begin
            wr(32'(i));
            if (i == 1022) check("full_at1023", 32'(addr_fifo_full), 32'd0);
            if (i == 1023) begin
                check("full_at1024", 32'(addr_fifo_full), 32'd1);
                check("ovr_at1024", 32'(addr_fifo_overrun), 32'd0);
            end
        end
        check("ovr_at1025", 32'(addr_fifo_overrun), 32'd1);
        check("words_full", 32'(words_in_addr_fifo), 32'd1024);

        // Program start clears sticky flags, keeps contents
        active_program = 1'b1;
        step();
        check("start_ovr", 32'(addr_fifo_overrun), 32'd0);
        check("start_udr", 32'(addr_fifo_underrun), 32'd0);
        check("start_words", 32'(words_in_addr_fifo), 32'd1024);

        // Write and pop together while full
        addr_fifo_wr = 1'b1; addr_fifo_din = 32'hDEAD_BEEF; addr_rd_en = 1'b1;
        step();
        addr_fifo_wr = 1'b0;
        check("wp_words", 32'(words_in_addr_fifo), 32'd1024);
        check("wp_ovr", 32'(addr_fifo_overrun), 32'd0);
        check("wp_full", 32'(addr_fifo_full), 32'd1);
        for (int i = 0; i < 1024; i++) exp_q.push_back(32'(i));
        exp_q.push_back(32'hDEAD_BEEF);
        for (int k = 0; k < 1030; k++) begin
            if (k == 1024) addr_rd_en = 1'b0;
            step();
            if (addr_dout_vld) begin
                if (exp_q.size() != 0) check("drain_data", addr_dout, exp_q.pop_front());
                else n_extra++;
            end
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_extra", 32'(n_extra), 32'd0);
        check("drain_empty", 32'(addr_fifo_empty), 32'd1);
        check("drain_udr", 32'(addr_fifo_underrun), 32'd0);
        active_program = 1'b0;
        step();

        // Histogram: first pop coincides with program start and is not binned
        wr(32'h100); wr(32'h101); wr(32'h102); wr(32'h103);
        active_program = 1'b1; addr_rd_en = 1'b1;
        step();
        check("coinc_cyc", 32'(addr_cycle_cnt), 32'd0);
        addr_rd_en = 1'b0;
        repeat (4) step();
        addr_rd_en = 1'b1; step(); addr_rd_en = 1'b0;
        repeat (19) step();
        check("cyc_19", 32'(addr_cycle_cnt), 32'd19);
        addr_rd_en = 1'b1; step(); addr_rd_en = 1'b0;
        check("cyc_restart", 32'(addr_cycle_cnt), 32'd0);
        repeat (199) step();
        addr_rd_en = 1'b1; step(); addr_rd_en = 1'b0;
        check("hist_empty", 32'(addr_fifo_empty), 32'd1);
        repeat (30) step();
        wr(32'h55);
        step();
        for (int i = 0; i < NBINS; i++) begin
            check($sformatf("mon_bin%0d", i), mon_bin(i),
                  (i == 0 || i == 2 || i == 15) ? HIT : 32'd0);
            check($sformatf("fifo_bin%0d", i), fifo_bin(i), (i == 3) ? HIT : 32'd0);
        end

        // Underrun then a new program start clears flags and bins
        addr_rd_en = 1'b1;
        step(); step();
        addr_rd_en = 1'b0;
        step();
        check("udr2_set", 32'(addr_fifo_underrun), 32'd1);
        check("bin4_hit", mon_bin(4), HIT);
        active_program = 1'b0; step();
        active_program = 1'b1; step();
        check("restart_udr", 32'(addr_fifo_underrun), 32'd0);
        check("restart_cyc", 32'(addr_cycle_cnt), 32'd0);
        check("restart_mon", addr_mon_cnts[31:0] | mon_bin(4) | mon_bin(15), 32'd0);
        check("restart_fifo", fifo_bin(3), 32'd0);

        // Asynchronous reset mid-operation
        wr(32'h77);
        check("pre_rst_words", 32'(words_in_addr_fifo), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("async_words", 32'(words_in_addr_fifo), 32'd0);
        check("async_empty", 32'(addr_fifo_empty), 32'd1);
        #2 reset = 1'b1;
        step();
        check("post_rst_empty", 32'(addr_fifo_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
